// File: rtl/seg7_card_reader.sv
// Recovers a card from active-low 7-seg drive lines, debounced, with valid/ready output.
// Define SEG7_READER_SCORE_EN to build the baccarat hand scorer.
module seg7_card_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [6:0] seg7,
  input  logic       clear,
  input  logic       card_ready,
  output logic [3:0] card,
  output logic       card_valid,
  output logic       code_err,
  output logic [3:0] hand_score,
  output logic [1:0] card_count,
  output logic       hand_ovf
);

  typedef enum logic [1:0] {
    WAIT_BLANK,
    ARMED,
    HOLD
  } state_e;

  state_e     state_q;
  logic [6:0] prev_q;
  logic [7:0] cnt_q;
  logic [3:0] card_q;
  logic       valid_q;
  logic       err_q;

  logic [3:0] dec_card;
  logic       is_blank;
  logic       is_card;
  logic       stable;
  logic       consume;

  // prev_q holds the pattern that the run counter has been counting
  always_comb begin
    dec_card = 4'd0;
    is_blank = 1'b0;
    unique case (prev_q)
      7'b0001000: dec_card = 4'd1;
      7'b0100100: dec_card = 4'd2;
      7'b0110000: dec_card = 4'd3;
      7'b0011001: dec_card = 4'd4;
      7'b0010010: dec_card = 4'd5;
      7'b0000010: dec_card = 4'd6;
      7'b1111000: dec_card = 4'd7;
      7'b0000000: dec_card = 4'd8;
      7'b0010000: dec_card = 4'd9;
      7'b1000000: dec_card = 4'd10;
      7'b1100001: dec_card = 4'd11;
      7'b0011000: dec_card = 4'd12;
      7'b0001001: dec_card = 4'd13;
      7'b1111111: is_blank = 1'b1;
      default:    dec_card = 4'd0;
    endcase
  end

  assign is_card = (dec_card != 4'd0);
  assign stable  = (cnt_q == 8'(STABLE_CYCLES));
  assign consume = valid_q && card_ready;

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= WAIT_BLANK;
      prev_q  <= '0;
      cnt_q   <= '0;
      card_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      prev_q <= seg7;
      err_q  <= 1'b0;
      if (seg7 != prev_q)
        cnt_q <= 8'd1;
      else if (cnt_q != 8'hff)
        cnt_q <= cnt_q + 8'd1;
      unique case (state_q)
        WAIT_BLANK: begin
          if (stable && is_blank) begin
            state_q <= ARMED;
            cnt_q   <= '0;
          end
        end
        ARMED: begin
          if (stable && !is_blank) begin
            cnt_q <= '0;
            if (is_card) begin
              state_q <= HOLD;
              card_q  <= dec_card;
              valid_q <= 1'b1;
            end else begin
              state_q <= WAIT_BLANK;
              err_q   <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (card_ready) begin
            state_q <= WAIT_BLANK;
            cnt_q   <= '0;
            card_q  <= '0;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= WAIT_BLANK;
      endcase
    end
  end

  assign card       = card_q;
  assign card_valid = valid_q;
  assign code_err   = err_q;

`ifdef SEG7_READER_SCORE_EN
  logic [3:0] score_q;
  logic [1:0] count_q;
  logic       ovf_q;
  logic [3:0] pts;
  logic [4:0] sum;

  assign pts = (card_q <= 4'd9) ? card_q : 4'd0;
  assign sum = {1'b0, score_q} + {1'b0, pts};

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      score_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (clear) begin
      score_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (consume) begin
      if (count_q == 2'd3) begin
        ovf_q <= 1'b1;
      end else begin
        score_q <= (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
        count_q <= count_q + 2'd1;
      end
    end
  end

  assign hand_score = score_q;
  assign card_count = count_q;
  assign hand_ovf   = ovf_q;
`else
  logic unused_score;
  assign unused_score = clear ^ consume;
  assign hand_score   = '0;
  assign card_count   = '0;
  assign hand_ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_card_reader.sv
// Bench for seg7_card_reader: directed vector table, async reset, random vs model.
// Scoring expectations follow SEG7_READER_SCORE_EN.
module tb_seg7_card_reader;

  localparam int N = 4;
`ifdef SEG7_READER_SCORE_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetb;
  logic [6:0] seg7;
  logic       clear;
  logic       card_ready;
  logic [3:0] card;
  logic       card_valid;
  logic       code_err;
  logic [3:0] hand_score;
  logic [1:0] card_count;
  logic       hand_ovf;

  seg7_card_reader #(.STABLE_CYCLES(N)) dut (
    .slow_clock(clk),
    .resetb(resetb),
    .seg7(seg7),
    .clear(clear),
    .card_ready(card_ready),
    .card(card),
    .card_valid(card_valid),
    .code_err(code_err),
    .hand_score(hand_score),
    .card_count(card_count),
    .hand_ovf(hand_ovf)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [6:0] codes [13] = '{
    7'b0001000, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b1000000,
    7'b1100001, 7'b0011000, 7'b0001001
  };
  localparam logic [6:0] BL = 7'b1111111;

  typedef struct {
    logic [6:0] seg;
    bit rdy;
    bit clr;
    int n;
    int card;
    bit v;
    bit e;
    int sc;
    int ct;
    bit ov;
  } vec_t;
  vec_t vq[$];

  function automatic int xs(int v);
    return SC ? v : 0;
  endfunction

  function automatic int m_decode(logic [6:0] s);
    for (int i = 0; i < 13; i++)
      if (s == codes[i]) return i + 1;
    if (s == BL) return 0;
    return -1;
  endfunction

  task automatic chk(string nm, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic chk_all(string t, int c, bit v, bit e, int sc, int ct, bit ov);
    chk({t, ".card"}, int'(card), c);
    chk({t, ".valid"}, int'(card_valid), int'(v));
    chk({t, ".err"}, int'(code_err), int'(e));
    chk({t, ".score"}, int'(hand_score), xs(sc));
    chk({t, ".count"}, int'(card_count), xs(ct));
    chk({t, ".ovf"}, int'(hand_ovf), xs(int'(ov)));
  endtask

  task automatic add(logic [6:0] s, bit r, bit c, int n,
                     int cd, bit v, bit e, int sc, int ct, bit ov);
    vq.push_back('{s, r, c, n, cd, v, e, sc, ct, ov});
  endtask

  task automatic apply(int idx);
    vec_t r;
    r = vq[idx];
    for (int k = 0; k < r.n; k++) begin
      seg7 = r.seg;
      card_ready = r.rdy;
      clear = r.clr;
      @(posedge clk);
      #1;
    end
    chk_all($sformatf("vec%0d", idx), r.card, r.v, r.e, r.sc, r.ct, r.ov);
  endtask

  // behavioural model
  logic [6:0] hist[$];
  bit m_armed, m_hold, m_err, m_ovf;
  int m_card, m_score, m_count;

  task automatic model_reset();
    hist.delete();
    m_armed = 0; m_hold = 0; m_err = 0; m_ovf = 0;
    m_card = 0; m_score = 0; m_count = 0;
  endtask

  task automatic model_edge(logic [6:0] s, bit rdy, bit clr);
    bit stab, moved, take;
    int sz, c;
    sz = hist.size();
    stab = 0;
    c = 0;
    if (sz >= N) begin
      stab = 1;
      for (int i = sz - N; i < sz; i++)
        if (hist[i] != hist[sz-1]) stab = 0;
      if (sz > N && hist[sz-N-1] == hist[sz-1]) stab = 0;
      c = m_decode(hist[sz-1]);
    end
    take = m_hold && rdy;
    if (clr) begin
      m_score = 0; m_count = 0; m_ovf = 0;
    end else if (take) begin
      if (m_count == 3) m_ovf = 1;
      else begin
        m_score = (m_score + ((m_card <= 9) ? m_card : 0)) % 10;
        m_count++;
      end
    end
    moved = 0;
    m_err = 0;
    if (m_hold) begin
      if (rdy) begin m_hold = 0; m_card = 0; moved = 1; end
    end else if (m_armed) begin
      if (stab && c != 0) begin
        moved = 1;
        m_armed = 0;
        if (c > 0) begin m_hold = 1; m_card = c; end
        else m_err = 1;
      end
    end else if (stab && c == 0) begin
      m_armed = 1;
      moved = 1;
    end
    if (moved) hist.delete();
    else begin
      hist.push_back(s);
      if (hist.size() > N + 1) void'(hist.pop_front());
    end
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    seg7 = BL;
    clear = 1'b0;
    card_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetb = 1'b1;
  endtask

  int split;

  initial begin
    do_reset();
    chk_all("reset", 0, 0, 0, 0, 0, 0);

    // first card then hand build-up with ready held high
    add(BL,         1, 0, 5, 0, 0, 0, 0, 0, 0);
    add(7'b0010010, 1, 0, 4, 0, 0, 0, 0, 0, 0);
    add(7'b0010010, 1, 0, 1, 5, 1, 0, 0, 0, 0);
    add(7'b0010010, 1, 0, 1, 0, 0, 0, 5, 1, 0);
    add(BL,         1, 0, 5, 0, 0, 0, 5, 1, 0);
    add(7'b0110000, 1, 0, 5, 3, 1, 0, 5, 1, 0);
    add(7'b0110000, 1, 0, 1, 0, 0, 0, 8, 2, 0);
    add(BL,         1, 0, 5, 0, 0, 0, 8, 2, 0);
    add(7'b0001001, 1, 0, 5, 13, 1, 0, 8, 2, 0);
    add(7'b0001001, 1, 0, 1, 0, 0, 0, 8, 3, 0);
    add(BL,         1, 0, 5, 0, 0, 0, 8, 3, 0);
    add(7'b0000000, 1, 0, 5, 8, 1, 0, 8, 3, 0);
    add(7'b0000000, 1, 0, 1, 0, 0, 0, 8, 3, 1);
    // invalid code while armed, then no re-arm without blank
    add(BL,         1, 0, 5, 0, 0, 0, 8, 3, 1);
    add(7'b0000011, 1, 0, 4, 0, 0, 0, 8, 3, 1);
    add(7'b0100100, 1, 0, 1, 0, 0, 1, 8, 3, 1);
    add(7'b0100100, 1, 0, 6, 0, 0, 0, 8, 3, 1);
    // glitch restarts the run
    add(BL,         1, 0, 5, 0, 0, 0, 8, 3, 1);
    add(7'b0100100, 1, 0, 3, 0, 0, 0, 8, 3, 1);
    add(7'b1111000, 1, 0, 1, 0, 0, 0, 8, 3, 1);
    add(7'b0100100, 1, 0, 4, 0, 0, 0, 8, 3, 1);
    add(7'b0100100, 1, 0, 1, 2, 1, 0, 8, 3, 1);
    add(7'b0100100, 1, 0, 1, 0, 0, 0, 8, 3, 1);
    // clear, then hold with ready low, then ready with clear
    add(BL,         1, 1, 5, 0, 0, 0, 0, 0, 0);
    add(7'b0010000, 1, 0, 5, 9, 1, 0, 0, 0, 0);
    add(7'b0010000, 1, 0, 1, 0, 0, 0, 9, 1, 0);
    add(BL,         1, 0, 5, 0, 0, 0, 9, 1, 0);
    add(7'b0011000, 0, 0, 5, 12, 1, 0, 9, 1, 0);
    add(7'b0010000, 0, 0, 8, 12, 1, 0, 9, 1, 0);
    add(7'b0010000, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    add(BL,         0, 0, 5, 0, 0, 0, 0, 0, 0);
    add(7'b0011001, 0, 0, 5, 4, 1, 0, 0, 0, 0);
    split = vq.size();
    // after async reset: card shown without blank is ignored
    add(7'b0011001, 0, 0, 10, 0, 0, 0, 0, 0, 0);
    add(BL,         0, 0, 5, 0, 0, 0, 0, 0, 0);
    add(7'b0011001, 0, 0, 5, 4, 1, 0, 0, 0, 0);

    for (int i = 0; i < split; i++) apply(i);

    #2 resetb = 1'b0;
    #1 chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 resetb = 1'b1;

    for (int i = split; i < vq.size(); i++) apply(i);

    // randomized run against the model
    do_reset();
    model_reset();
    begin
      int left;
      logic [6:0] s;
      bit r, c;
      left = 0;
      s = BL;
      for (int cyc = 0; cyc < 4000; cyc++) begin
        if (left == 0) begin
          int p;
          p = $urandom_range(0, 99);
          if (p < 40) s = BL;
          else if (p < 85) s = codes[$urandom_range(0, 12)];
          else begin
            s = 7'($urandom_range(0, 127));
            while (m_decode(s) != -1) s = 7'($urandom_range(0, 127));
          end
          left = $urandom_range(1, 8);
        end
        left--;
        r = ($urandom_range(0, 2) != 0);
        c = ($urandom_range(0, 49) == 0);
        seg7 = s;
        card_ready = r;
        clear = c;
        @(posedge clk);
        model_edge(s, r, c);
        #1;
        chk_all($sformatf("rnd%0d", cyc), m_card, m_hold, m_err,
                m_score, m_count, m_ovf);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
